// File: rtl/pixel_deser.sv
// pixel_deser: capture side of the MDA pixel serializer.
// Samples one pixel per pixclk, uses hsync/vsync to find the active area,
// rebuilds each 9-pixel character cell (8-bit row byte + 9th column bit)
// tagged with column/row, and hands cells downstream over valid/ready.
// Optional feature macro: BOX_DUP_CHECK_EN adds the box_mismatch output,
// flagging cells whose 9th column is not a copy of pixel 7.
module pixel_deser #(
  parameter int H_CHARS     = 80,
  parameter int H_BACKPORCH = 15,
  parameter int V_LINES     = 350,
  parameter int V_BACKPORCH = 4
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic       pix_in,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] out_line,
  output logic       out_col9,
  output logic [6:0] out_col,
  output logic [8:0] out_row,
  output logic       out_sof,
  output logic       out_valid,
`ifdef BOX_DUP_CHECK_EN
  output logic       box_mismatch,
`endif
  input  logic       out_ready,
  output logic       err_overflow,
  output logic       err_short
);

  typedef enum logic [2:0] {
    IDLE,
    VBP,
    WAIT_H,
    HBP,
    ACTIVE,
    LINE_END
  } state_t;

  // Sized copies of the geometry so every compare is width-matched.
  localparam logic [6:0]  LAST_COL  = 7'(H_CHARS - 1);
  localparam logic [9:0]  ROW_LIMIT = 10'(V_LINES);
  localparam logic [15:0] SKIP_LAST = 16'(V_BACKPORCH);
  localparam logic [15:0] HBP_LAST  = (H_BACKPORCH > 1) ? 16'(H_BACKPORCH - 1) : 16'd0;

  state_t      state_q, state_d;
  logic        hs_dly_q, vs_dly_q;
  logic [15:0] skip_q, skip_d;
  logic [15:0] hbp_q, hbp_d;
  logic [3:0]  pix_cnt_q, pix_cnt_d;
  logic [6:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [7:0]  shift_q, shift_d;

  logic [7:0]  out_line_q, out_line_d;
  logic        out_col9_q, out_col9_d;
  logic [6:0]  out_col_q, out_col_d;
  logic [8:0]  out_row_q, out_row_d;
  logic        out_sof_q, out_sof_d;
  logic        out_valid_q, out_valid_d;
  logic        err_overflow_q, err_overflow_d;
  logic        err_short_q, err_short_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        line_go;
  logic        short_hit;
  logic        cell_done;
  logic        cell_col9;
  logic        transfer;

  // Sync edges are judged against the previous cycle's level, in the same
  // cycle the raw input changes.
  always_comb begin
    hs_fall = hs_dly_q & ~hsync;
    hs_rise = ~hs_dly_q & hsync;
    vs_fall = vs_dly_q & ~vsync;
    vs_rise = ~vs_dly_q & vsync;
  end

  // Frame/line sequencing: back porches, pixel capture, cell completion.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    hbp_d     = hbp_q;
    pix_cnt_d = pix_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    shift_d   = shift_q;
    line_go   = 1'b0;
    short_hit = 1'b0;
    cell_done = 1'b0;
    cell_col9 = 1'b0;

    case (state_q)
      IDLE: begin
        if (vs_fall) begin
          state_d   = VBP;
          row_d     = 10'd0;
          skip_d    = 16'd0;
          col_d     = 7'd0;
          pix_cnt_d = 4'd0;
        end
      end
      VBP: begin
        if (hs_fall) begin
          if (skip_q == SKIP_LAST) begin
            line_go = 1'b1;
          end else begin
            skip_d = skip_q + 16'd1;
          end
        end
      end
      WAIT_H: begin
        if (hs_fall) begin
          if (row_q < ROW_LIMIT) begin
            line_go = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HBP: begin
        if (hs_rise) begin
          short_hit = 1'b1;
        end else if (hbp_q == HBP_LAST) begin
          state_d = ACTIVE;
        end else begin
          hbp_d = hbp_q + 16'd1;
        end
      end
      ACTIVE: begin
        if (hs_rise) begin
          short_hit = 1'b1;
        end else if (pix_cnt_q == 4'd8) begin
          cell_done = 1'b1;
          cell_col9 = pix_in;
          pix_cnt_d = 4'd0;
          if (col_q == LAST_COL) begin
            state_d = LINE_END;
            col_d   = 7'd0;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          shift_d[pix_cnt_q[2:0]] = pix_in;
          pix_cnt_d               = pix_cnt_q + 4'd1;
        end
      end
      LINE_END: begin
        row_d   = row_q + 10'd1;
        state_d = WAIT_H;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The hsync-fall cycle counts as back-porch cycle 0; with no back porch
    // that very cycle already carries pixel 0.
    if (line_go) begin
      col_d     = 7'd0;
      pix_cnt_d = 4'd0;
      hbp_d     = 16'd1;
      shift_d   = 8'd0;
      if (H_BACKPORCH == 0) begin
        shift_d[0] = pix_in;
        pix_cnt_d  = 4'd1;
        state_d    = ACTIVE;
      end else if (H_BACKPORCH == 1) begin
        state_d = ACTIVE;
      end else begin
        state_d = HBP;
      end
    end

    // A premature hsync drops the partial cell and moves on to the next line.
    if (short_hit) begin
      state_d   = WAIT_H;
      row_d     = row_q + 10'd1;
      col_d     = 7'd0;
      pix_cnt_d = 4'd0;
    end

    // vsync rising outranks everything else and abandons the frame.
    if ((state_q != IDLE) && vs_rise) begin
      state_d   = IDLE;
      col_d     = 7'd0;
      pix_cnt_d = 4'd0;
      row_d     = row_q;
      cell_done = 1'b0;
      short_hit = 1'b0;
    end
  end

  // Single holding register for completed cells plus the sticky error flags.
  always_comb begin
    out_line_d     = out_line_q;
    out_col9_d     = out_col9_q;
    out_col_d      = out_col_q;
    out_row_d      = out_row_q;
    out_sof_d      = out_sof_q;
    out_valid_d    = out_valid_q;
    err_overflow_d = err_overflow_q;
    err_short_d    = err_short_q;
    transfer       = out_valid_q & out_ready;

    if (cell_done) begin
      if (!out_valid_q || transfer) begin
        out_line_d  = shift_q;
        out_col9_d  = cell_col9;
        out_col_d   = col_q;
        out_row_d   = row_q[8:0];
        out_sof_d   = (col_q == 7'd0) && (row_q == 10'd0);
        out_valid_d = 1'b1;
      end else begin
        err_overflow_d = 1'b1;
      end
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end

    if (short_hit) begin
      err_short_d = 1'b1;
    end
  end

  // Capture-side state, counters and sync history.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q   <= IDLE;
      hs_dly_q  <= 1'b0;
      vs_dly_q  <= 1'b0;
      skip_q    <= 16'd0;
      hbp_q     <= 16'd0;
      pix_cnt_q <= 4'd0;
      col_q     <= 7'd0;
      row_q     <= 10'd0;
      shift_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      hs_dly_q  <= hsync;
      vs_dly_q  <= vsync;
      skip_q    <= skip_d;
      hbp_q     <= hbp_d;
      pix_cnt_q <= pix_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      shift_q   <= shift_d;
    end
  end

  // Output holding register and sticky errors.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      out_line_q     <= 8'd0;
      out_col9_q     <= 1'b0;
      out_col_q      <= 7'd0;
      out_row_q      <= 9'd0;
      out_sof_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      out_line_q     <= out_line_d;
      out_col9_q     <= out_col9_d;
      out_col_q      <= out_col_d;
      out_row_q      <= out_row_d;
      out_sof_q      <= out_sof_d;
      out_valid_q    <= out_valid_d;
      err_overflow_q <= err_overflow_d;
      err_short_q    <= err_short_d;
    end
  end

  assign out_line     = out_line_q;
  assign out_col9     = out_col9_q;
  assign out_col      = out_col_q;
  assign out_row      = out_row_q;
  assign out_sof      = out_sof_q;
  assign out_valid    = out_valid_q;
  assign err_overflow = err_overflow_q;
  assign err_short    = err_short_q;

`ifdef BOX_DUP_CHECK_EN
  assign box_mismatch = out_col9_q ^ out_line_q[7];
`endif

endmodule

// File: tb/tb_pixel_deser.sv
// tb_pixel_deser: directed bench for pixel_deser on a tiny 2x2-cell frame.
// Build with BOX_DUP_CHECK_EN defined to also exercise box_mismatch.
module tb_pixel_deser;

  localparam int H_CHARS     = 2;
  localparam int H_BACKPORCH = 3;
  localparam int V_LINES     = 2;
  localparam int V_BACKPORCH = 1;

  logic       pixclk = 1'b0;
  logic       rst;
  logic       pix_in;
  logic       hsync;
  logic       vsync;
  logic       out_ready;
  logic [7:0] out_line;
  logic       out_col9;
  logic [6:0] out_col;
  logic [8:0] out_row;
  logic       out_sof;
  logic       out_valid;
  logic       err_overflow;
  logic       err_short;
`ifdef BOX_DUP_CHECK_EN
  logic       box_mismatch;
`endif

  int errors    = 0;
  int checks    = 0;
  int xferCount = 0;
  int xferBase  = 0;
  int idx;

  // One nominal cell: its nine pixels and the outputs it must produce.
  typedef struct {
    logic [8:0] pix;
    logic [7:0] expLine;
    logic       expCol9;
    logic [6:0] expCol;
    logic [8:0] expRow;
    logic       expSof;
  } cellVec_t;

  cellVec_t nominal [4];

  pixel_deser #(
    .H_CHARS    (H_CHARS),
    .H_BACKPORCH(H_BACKPORCH),
    .V_LINES    (V_LINES),
    .V_BACKPORCH(V_BACKPORCH)
  ) dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .pix_in      (pix_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .out_line    (out_line),
    .out_col9    (out_col9),
    .out_col     (out_col),
    .out_row     (out_row),
    .out_sof     (out_sof),
    .out_valid   (out_valid),
`ifdef BOX_DUP_CHECK_EN
    .box_mismatch(box_mismatch),
`endif
    .out_ready   (out_ready),
    .err_overflow(err_overflow),
    .err_short   (err_short)
  );

  // Free-running pixel clock.
  always #5 pixclk = ~pixclk;

  // Count every accepted cell so frames can be checked for extra/missing cells.
  always @(posedge pixclk) begin
    if (out_valid && out_ready) xferCount <= xferCount + 1;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic applyStimulus(input logic p, input logic h, input logic v, input logic r);
    pix_in    = p;
    hsync     = h;
    vsync     = v;
    out_ready = r;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // vsync pulse, its falling edge, then the skipped back-porch lines.
  task automatic startFrame(input logic r);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, r);
    applyStimulus(1'b0, 1'b0, 1'b0, r);
    for (int i = 0; i < V_BACKPORCH; i++) begin
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, r);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, r);
    end
  endtask

  // hsync pulse, then the back-porch cycles (fall cycle included).
  task automatic lineStart(input logic r);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, r);
    repeat (H_BACKPORCH) applyStimulus(1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic lineEnd(input logic r);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic sendPixels(input logic [8:0] pix, input int first, input int last, input logic r);
    for (int k = first; k <= last; k++) applyStimulus(pix[k], 1'b0, 1'b0, r);
  endtask

  initial begin
    nominal[0] = '{9'h18D, 8'h8D, 1'b1, 7'd0, 9'd0, 1'b1};
    nominal[1] = '{9'h03C, 8'h3C, 1'b0, 7'd1, 9'd0, 1'b0};
    nominal[2] = '{9'h1FF, 8'hFF, 1'b1, 7'd0, 9'd1, 1'b0};
    nominal[3] = '{9'h0A5, 8'hA5, 1'b0, 7'd1, 9'd1, 1'b0};

    // Reset with random sync activity: every output must sit at 0.
    rst = 1'b1;
    repeat (3) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkOutput("reset out_line", out_line, 0);
    checkOutput("reset out_col9", out_col9, 0);
    checkOutput("reset out_col", out_col, 0);
    checkOutput("reset out_row", out_row, 0);
    checkOutput("reset out_sof", out_sof, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset err_overflow", err_overflow, 0);
    checkOutput("reset err_short", err_short, 0);
    rst = 1'b0;

    // Lines without any vsync fall must not produce cells.
    lineStart(1'b1);
    sendPixels(9'h1FF, 0, 8, 1'b1);
    checkOutput("idle out_valid", out_valid, 0);

    // Nominal frame, table driven.
    xferBase = xferCount;
    startFrame(1'b1);
    for (int ln = 0; ln < V_LINES; ln++) begin
      lineStart(1'b1);
      for (int c = 0; c < H_CHARS; c++) begin
        idx = ln * H_CHARS + c;
        sendPixels(nominal[idx].pix, 0, 7, 1'b1);
        checkOutput($sformatf("nominal[%0d] valid before pix8", idx), out_valid, 0);
        sendPixels(nominal[idx].pix, 8, 8, 1'b1);
        checkOutput($sformatf("nominal[%0d] valid", idx), out_valid, 1);
        checkOutput($sformatf("nominal[%0d] line", idx), out_line, nominal[idx].expLine);
        checkOutput($sformatf("nominal[%0d] col9", idx), out_col9, nominal[idx].expCol9);
        checkOutput($sformatf("nominal[%0d] col", idx), out_col, nominal[idx].expCol);
        checkOutput($sformatf("nominal[%0d] row", idx), out_row, nominal[idx].expRow);
        checkOutput($sformatf("nominal[%0d] sof", idx), out_sof, nominal[idx].expSof);
      end
      lineEnd(1'b1);
    end
    // A line past the last row must be ignored.
    lineStart(1'b1);
    sendPixels(9'h1FF, 0, 8, 1'b1);
    sendPixels(9'h1FF, 0, 8, 1'b1);
    lineEnd(1'b1);
    checkOutput("nominal cell count", xferCount - xferBase, 4);
    checkOutput("nominal final valid", out_valid, 0);

    // Ready pulses exactly as the next cell completes.
    startFrame(1'b0);
    lineStart(1'b0);
    sendPixels(9'h0F0, 0, 8, 1'b0);
    checkOutput("simul first valid", out_valid, 1);
    checkOutput("simul first line", out_line, 8'hF0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(9'h155 >> k, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("simul hold valid px%0d", k), out_valid, 1);
      checkOutput($sformatf("simul hold line px%0d", k), out_line, 8'hF0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("simul new valid", out_valid, 1);
    checkOutput("simul new line", out_line, 8'h55);
    checkOutput("simul new col9", out_col9, 1);
    checkOutput("simul new col", out_col, 1);
    checkOutput("simul no overflow", err_overflow, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("simul drain valid", out_valid, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure across two completions.
    lineStart(1'b0);
    sendPixels(9'h0C3, 0, 8, 1'b0);
    checkOutput("bp first valid", out_valid, 1);
    checkOutput("bp first line", out_line, 8'hC3);
    checkOutput("bp first row", out_row, 1);
    sendPixels(9'h13C, 0, 8, 1'b0);
    checkOutput("bp overflow", err_overflow, 1);
    checkOutput("bp held valid", out_valid, 1);
    checkOutput("bp held line", out_line, 8'hC3);
    checkOutput("bp held col", out_col, 0);
    checkOutput("bp held col9", out_col9, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp drain valid", out_valid, 0);
    checkOutput("bp overflow sticky", err_overflow, 1);

    // Reset mid-frame clears everything, sticky errors included.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("midrst err_overflow", err_overflow, 0);
    checkOutput("midrst out_valid", out_valid, 0);
    checkOutput("midrst out_line", out_line, 0);
    lineStart(1'b1);
    sendPixels(9'h1FF, 0, 8, 1'b1);
    checkOutput("midrst no capture", out_valid, 0);

    // Short line: hsync rises at pixel 4 of column 1.
    xferBase = xferCount;
    startFrame(1'b1);
    lineStart(1'b1);
    sendPixels(9'h1AA, 0, 8, 1'b1);
    checkOutput("short c00 line", out_line, 8'hAA);
    checkOutput("short c00 sof", out_sof, 1);
    sendPixels(9'h0FF, 0, 3, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("short err_short", err_short, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (H_BACKPORCH) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("short cells so far", xferCount - xferBase, 1);
    sendPixels(9'h066, 0, 8, 1'b1);
    checkOutput("short next valid", out_valid, 1);
    checkOutput("short next col", out_col, 0);
    checkOutput("short next row", out_row, 1);
    checkOutput("short next line", out_line, 8'h66);
    checkOutput("short next sof", out_sof, 0);

    // vsync rise mid-cell aborts; the next frame restarts at (0,0).
    sendPixels(9'h1FF, 0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("abort no valid", out_valid, 0);
    checkOutput("abort cell count", xferCount - xferBase, 2);
    startFrame(1'b1);
    lineStart(1'b1);
    sendPixels(9'h080, 0, 8, 1'b1);
    checkOutput("restart valid", out_valid, 1);
    checkOutput("restart sof", out_sof, 1);
    checkOutput("restart col", out_col, 0);
    checkOutput("restart row", out_row, 0);
    checkOutput("restart line", out_line, 8'h80);
`ifdef BOX_DUP_CHECK_EN
    checkOutput("box mismatch p7=1 p8=0", box_mismatch, 1);
`endif
    sendPixels(9'h180, 0, 8, 1'b1);
    checkOutput("box2 col", out_col, 1);
    checkOutput("box2 col9", out_col9, 1);
`ifdef BOX_DUP_CHECK_EN
    checkOutput("box mismatch p7=1 p8=1", box_mismatch, 0);
`endif
    lineEnd(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
